// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the single-port RAM arbiter between the
// instruction-fetch and data-memory paths.
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEF_MAX_DSTREAK = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  // Bits needed to hold 0..max_count; never narrower than one bit.
  function automatic int unsigned streak_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_streak.sv
// Saturating counter of consecutive data grants taken while a fetch waits.
// Clear wins over increment; at_max flags the saturation value.
module mem_arbiter_streak
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = DEF_MAX_DSTREAK
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int unsigned CW = streak_width(MAX_COUNT);
  localparam logic [CW-1:0] CMAX = CW'(MAX_COUNT);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CMAX)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == CMAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between fetch and data accesses. Data wins by
// default; after MAX_DSTREAK data grants with a fetch pending, fetch is granted.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = DEF_MAX_DSTREAK,
  parameter int unsigned ADDR_W      = WORD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction fetch side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] iload,
  output logic              iwait,
  // data memory side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic [ADDR_W-1:0] dload,
  output logic              dwait,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic              ramready,
  output logic              busy
);

  arb_state_t state;
  arb_state_t next_state;

  logic dreq;
  logic streak_clr;
  logic streak_inc;
  logic streak_max;
  logic ibusy;
  logic dbusy;
  logic idone;
  logic ddone;

  assign dreq = dREN | dWEN;

  mem_arbiter_streak #(
    .MAX_COUNT (MAX_DSTREAK)
  ) u_streak (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (streak_clr),
    .inc    (streak_inc),
    .at_max (streak_max)
  );

  // Grant decision in IDLE; busy states leave on completion or when the owner
  // drops its request (abort leaves the streak untouched).
  always_comb begin
    next_state = state;
    streak_clr = 1'b0;
    streak_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq && !(iREN && streak_max)) begin
          next_state = DBUSY;
          streak_inc = iREN;
          streak_clr = ~iREN;
        end else if (iREN) begin
          next_state = IBUSY;
          streak_clr = 1'b1;
        end
      end
      IBUSY: begin
        if (ramready || !iREN) begin
          next_state = IDLE;
        end
      end
      DBUSY: begin
        if (ramready || !dreq) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
    end
  end

  assign ibusy = (state == IBUSY);
  assign dbusy = (state == DBUSY);
  assign idone = ibusy & ramready;
  assign ddone = dbusy & ramready;

  assign iwait = iREN & ~idone;
  assign dwait = dreq & ~ddone;
  assign iload = idone ? ramload : '0;
  assign dload = ddone ? ramload : '0;

  // RAM drive follows the live requester inputs so address changes pass through.
  assign ramREN   = ibusy | (dbusy & dREN & ~dWEN);
  assign ramWEN   = dbusy & dWEN;
  assign ramaddr  = ibusy ? iaddr : (dbusy ? daddr : '0);
  assign ramstore = dbusy ? dstore : '0;

endmodule
